// File: rtl/rmii_frame_rx.sv
`default_nettype none
// ============================================================================
//  Module   : rmii_frame_rx
//  Purpose  : RMII receive framer. Samples CRS_DV/RXD on the 50 MHz reference
//             clock, strips preamble and SFD, packs dibits LSB-first into
//             bytes and writes them into the packet buffer RAM. Reports frame
//             length, FCS status and error status with a one-cycle done pulse.
//  Ports    : clk_i, reset_i (async, active-high)
//             crsdv_i, rxd_i[1:0], rxerr_i   - RMII receive pins (pre-synced)
//             base_addr_i                    - RAM address of first byte
//             ram_we_o, ram_waddr_o, ram_win_o - RAM write port
//             busy_o, done_o, frame_len_o, crc_ok_o, frame_err_o - status
//  Config   : RMII_RX_CRC_CHECK_EN - build the CRC-32 FCS residue checker;
//             without it crc_ok reports ~frame_err.
//  Revision : 1.0 - initial release
// ============================================================================
module rmii_frame_rx #(
    parameter int  RAM_SIZE      = 2048,
    parameter int  MAX_FRAME_LEN = 1522,
    parameter int  MIN_PREAMBLE  = 8,
    localparam int AW            = $clog2(RAM_SIZE)
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          crsdv_i,
    input  logic [1:0]    rxd_i,
    input  logic          rxerr_i,
    input  logic [AW-1:0] base_addr_i,
    output logic          ram_we_o,
    output logic [AW-1:0] ram_waddr_o,
    output logic [7:0]    ram_win_o,
    output logic          busy_o,
    output logic          done_o,
    output logic [10:0]   frame_len_o,
    output logic          crc_ok_o,
    output logic          frame_err_o
);

    localparam logic [4:0]  C_MIN_PRE = 5'(MIN_PREAMBLE);
    localparam logic [10:0] C_MAX_LEN = 11'(MAX_FRAME_LEN);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_PREAMBLE = 2'd1,
        S_DATA     = 2'd2,
        S_DROP     = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [4:0]    pre_cnt_q, pre_cnt_d;
    logic [AW-1:0] base_q, base_d;
    logic [10:0]   byte_cnt_q, byte_cnt_d;
    logic [1:0]    phase_q, phase_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          err_q, err_d;
    logic          we_q, we_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [7:0]    win_q, win_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [10:0]   len_q, len_d;
    logic          crc_ok_q, crc_ok_d;
    logic          ferr_q, ferr_d;

    // Byte completed by the current dibit (valid when phase_q == 3).
    logic [7:0] w_byte;
    assign w_byte = {rxd_i, shreg_q[7:2]};

    // Frame error at a normal end of frame: sticky rxerr, or a partial byte.
    logic w_end_err;
    assign w_end_err = err_q | rxerr_i | (phase_q != 2'd0);

    logic w_crc_good;

`ifdef RMII_RX_CRC_CHECK_EN
    localparam logic [31:0] C_CRC_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] C_CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] C_CRC_RESIDUE = 32'hDEBB_20E3;

    logic [31:0] crc_q, crc_d;

    function automatic logic [31:0] f_crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'd0, b};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ C_CRC_POLY) : (r >> 1);
        end
        return r;
    endfunction

    // Running over data plus FCS leaves the fixed residue on a good frame.
    assign w_crc_good = (crc_q == C_CRC_RESIDUE);
`else
    assign w_crc_good = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        pre_cnt_d  = pre_cnt_q;
        base_d     = base_q;
        byte_cnt_d = byte_cnt_q;
        phase_d    = phase_q;
        shreg_d    = shreg_q;
        err_d      = err_q;
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        win_d      = win_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        len_d      = len_q;
        crc_ok_d   = crc_ok_q;
        ferr_d     = ferr_q;
`ifdef RMII_RX_CRC_CHECK_EN
        crc_d      = crc_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (crsdv_i && rxd_i == 2'b01) begin
                    state_d    = S_PREAMBLE;
                    pre_cnt_d  = 5'd1;
                    byte_cnt_d = '0;
                    err_d      = 1'b0;
                end
            end
            S_PREAMBLE: begin
                if (!crsdv_i) begin
                    state_d = S_IDLE;
                end else if (rxd_i == 2'b01) begin
                    if (pre_cnt_q != 5'd31) pre_cnt_d = pre_cnt_q + 5'd1;
                end else if (rxd_i == 2'b11) begin
                    if (pre_cnt_q >= C_MIN_PRE) begin
                        state_d    = S_DATA;
                        base_d     = base_addr_i;
                        byte_cnt_d = '0;
                        phase_d    = 2'd0;
                        err_d      = 1'b0;
                        busy_d     = 1'b1;
`ifdef RMII_RX_CRC_CHECK_EN
                        crc_d      = C_CRC_INIT;
`endif
                    end else begin
                        // Too short a preamble: swallow the rest of the frame.
                        state_d = S_DROP;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DATA: begin
                if (rxerr_i) err_d = 1'b1;
                if (!crsdv_i) begin
                    // Any write from the final dibit is already on the port.
                    state_d  = S_IDLE;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    len_d    = byte_cnt_q;
                    ferr_d   = w_end_err;
                    crc_ok_d = w_crc_good & ~w_end_err;
                end else begin
                    shreg_d = w_byte;
                    phase_d = phase_q + 2'd1;
                    if (phase_q == 2'd3) begin
                        if (byte_cnt_q == C_MAX_LEN) begin
                            state_d = S_DROP;
                        end else begin
                            we_d       = 1'b1;
                            win_d      = w_byte;
                            waddr_d    = base_q + AW'(byte_cnt_q);
                            byte_cnt_d = byte_cnt_q + 11'd1;
`ifdef RMII_RX_CRC_CHECK_EN
                            crc_d      = f_crc_byte(crc_q, w_byte);
`endif
                        end
                    end
                end
            end
            S_DROP: begin
                if (!crsdv_i) begin
                    state_d  = S_IDLE;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    len_d    = byte_cnt_q;
                    ferr_d   = 1'b1;
                    crc_ok_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            pre_cnt_q  <= '0;
            base_q     <= '0;
            byte_cnt_q <= '0;
            phase_q    <= '0;
            shreg_q    <= '0;
            err_q      <= 1'b0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            win_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            len_q      <= '0;
            crc_ok_q   <= 1'b0;
            ferr_q     <= 1'b0;
`ifdef RMII_RX_CRC_CHECK_EN
            crc_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            pre_cnt_q  <= pre_cnt_d;
            base_q     <= base_d;
            byte_cnt_q <= byte_cnt_d;
            phase_q    <= phase_d;
            shreg_q    <= shreg_d;
            err_q      <= err_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            win_q      <= win_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            len_q      <= len_d;
            crc_ok_q   <= crc_ok_d;
            ferr_q     <= ferr_d;
`ifdef RMII_RX_CRC_CHECK_EN
            crc_q      <= crc_d;
`endif
        end
    end

    assign ram_we_o    = we_q;
    assign ram_waddr_o = waddr_q;
    assign ram_win_o   = win_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign frame_len_o = len_q;
    assign crc_ok_o    = crc_ok_q;
    assign frame_err_o = ferr_q;

endmodule
`default_nettype wire
